// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared constants and pointer helper for the FIFO read-side stream adapter.
// FWFT_DEPTH sizes the skid queue that covers the one-clock dpram read latency.
package fifo_rd_stream_adapter_pkg;

  localparam int FWFT_DEPTH = 3;
  localparam int PTR_W      = 2;
  localparam int OCC_W      = 2;

  // Circular pointer step with wrap at FWFT_DEPTH (2 -> 0).
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FWFT_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_fwft_reg_queue.sv
// Three-entry register queue that buffers words returned by the FIFO read port.
// The head entry is presented directly, so the stream side sees it without extra latency.
module fwft_reg_queue
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DataWidth = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic [DataWidth-1:0] i_pushData,
  input  logic                 i_pop,
  input  logic                 i_flush,
  output logic [OCC_W-1:0]     o_occ,
  output logic [DataWidth-1:0] o_head
);

  logic [DataWidth-1:0] r_mem [FWFT_DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [OCC_W-1:0]     r_occ;

  // Flush discards both pointers and the count; entry contents are left stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FWFT_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= nextPtr(r_wrPtr);
      end
      if (i_pop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      if (i_push && !i_pop) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (!i_push && i_pop) begin
        r_occ <= r_occ - OCC_W'(1);
      end
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rdPtr];

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a FIFO read port (q valid one clock after rd) into a first-word-fall-through
// valid/ready stream; reads are issued on credit so m_ready never reaches fifo_rd.
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int data_width = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width-1:0] fifo_q,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic                  flush,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            level
);

  logic             r_active;
  logic             r_inflight;
  logic [OCC_W-1:0] w_occ;
  logic [OCC_W:0]   w_credit;
  logic             w_rd;
  logic             w_pop;

  // Buffered plus in-flight words must leave room for the word a new read will return.
  assign w_credit = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight};
  assign w_rd     = r_active && !fifo_empty && !flush
                    && (w_credit < (OCC_W + 1)'(FWFT_DEPTH));
  assign w_pop    = m_valid && m_ready;

  // r_active holds reads off until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_active   <= 1'b1;
      r_inflight <= w_rd;
    end
  end

  fwft_reg_queue #(
    .DataWidth(data_width)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (r_inflight),
    .i_pushData(fifo_q),
    .i_pop     (w_pop),
    .i_flush   (flush),
    .o_occ     (w_occ),
    .o_head    (m_data)
  );

  assign fifo_rd = w_rd;
  assign m_valid = (w_occ != '0);
  assign level   = w_occ;

endmodule
